// File: rtl/mem_bus_arbiter.sv
// Two-port memory bus arbiter: instruction fetch (port 0) and data (port 1)
// share one downstream memory port, one transaction at a time.
//
// Ports:
//   clk, reset_n         rising-edge clock, synchronous active-low reset
//   m0_* / m1_*          requester ports: valid/addr/wdata/wstrb in,
//                        ready (one-cycle completion pulse) and rdata out
//   s_valid/addr/wdata/wstrb  downstream request, held until s_ready
//   s_ready, s_rdata     downstream completion pulse and read data
//   grant                one-hot downstream owner, 00 when idle/done
// RR_EN=1 alternates on ties, RR_EN=0 gives port 0 fixed priority.
module mem_bus_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    // 1 when port 1 was granted most recently
    logic   last_grant;
    logic   pick1;

    // Port 1 wins when alone, or on a tie when round-robin says port 0
    // had the previous turn.
    always_comb begin
        pick1 = 1'b0;
        if (m1_valid && !m0_valid) begin
            pick1 = 1'b1;
        end else if (m1_valid && m0_valid && RR_EN) begin
            pick1 = !last_grant;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            s_valid    <= 1'b0;
            s_addr     <= '0;
            s_wdata    <= '0;
            s_wstrb    <= '0;
            m0_ready   <= 1'b0;
            m1_ready   <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
            grant      <= 2'b00;
        end else begin
            m0_ready <= 1'b0;
            m1_ready <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (m0_valid || m1_valid) begin
                        s_valid    <= 1'b1;
                        last_grant <= pick1;
                        if (pick1) begin
                            state   <= BUSY1;
                            grant   <= 2'b10;
                            s_addr  <= m1_addr;
                            s_wdata <= m1_wdata;
                            s_wstrb <= m1_wstrb;
                        end else begin
                            state   <= BUSY0;
                            grant   <= 2'b01;
                            s_addr  <= m0_addr;
                            s_wdata <= m0_wdata;
                            s_wstrb <= m0_wstrb;
                        end
                    end
                end
                BUSY0: begin
                    if (s_ready) begin
                        state    <= DONE;
                        s_valid  <= 1'b0;
                        grant    <= 2'b00;
                        m0_ready <= 1'b1;
                        m0_rdata <= s_rdata;
                    end
                end
                BUSY1: begin
                    if (s_ready) begin
                        state    <= DONE;
                        s_valid  <= 1'b0;
                        grant    <= 2'b00;
                        m1_ready <= 1'b1;
                        m1_rdata <= s_rdata;
                    end
                end
                // One dead cycle so a requester still holding valid
                // while it sees ready is not granted again.
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
